alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 22 ++
 rtl/flag_reg.sv | 53 +++++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states
// and flag bit positions.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

endpackage

// File: rtl/flag_reg.sv
// V/N/Z flag storage with opcode-dependent write enables; updated only on
// the cycle the arbiter captures an ALU result.
module flag_reg
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              update_i,
  input  logic [OP_W-1:0]   opcode_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic              ovfl_i,
  output logic [2:0]        flags_o
);

  logic [2:0] flags_q;
  logic [2:0] flags_d;
  logic       we_all;
  logic       we_z;

  always_comb begin
    we_all = (opcode_i == OP_W'(OP_ADD)) || (opcode_i == OP_W'(OP_SUB));
    we_z   = we_all ||
             (opcode_i == OP_W'(OP_XOR)) || (opcode_i == OP_W'(OP_SLL)) ||
             (opcode_i == OP_W'(OP_SRA)) || (opcode_i == OP_W'(OP_ROR));
  end

  always_comb begin
    flags_d = flags_q;
    if (update_i) begin
      if (we_all) begin
        flags_d[FLAG_V] = ovfl_i;
        flags_d[FLAG_N] = result_i[DATA_W-1];
      end
      if (we_z) begin
        flags_d[FLAG_Z] = (result_i == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters,
// one transaction in flight: IDLE (grant) -> EXEC (capture) -> RESP (handshake).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*OP_W-1:0]   req_opcode,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic [OP_W-1:0]     alu_opcode,
  output logic [DATA_W-1:0]   alu_op1,
  output logic [DATA_W-1:0]   alu_op2,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_ovfl,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic [2:0]          flags
);

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                gnt_q, gnt_d;
  logic [OP_W-1:0]     opcode_q, opcode_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;

  logic [OP_W-1:0]     op_arr [2];
  logic [DATA_W-1:0]   a_arr  [2];
  logic [DATA_W-1:0]   b_arr  [2];
  logic                gnt_sel;
  logic [1:0]          grant_vec;
  logic [1:0]          resp_vec;

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign op_arr[gi] = req_opcode[gi*OP_W +: OP_W];
    assign a_arr[gi]  = req_a[gi*DATA_W +: DATA_W];
    assign b_arr[gi]  = req_b[gi*DATA_W +: DATA_W];
  end

  // Pointer only matters when both requesters contend.
  assign gnt_sel = (req_valid == 2'b11) ? ptr_q : req_valid[1];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    opcode_d    = opcode_q;
    a_d         = a_q;
    b_d         = b_q;
    resp_data_d = resp_data_q;
    grant_vec   = 2'b00;
    resp_vec    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (req_valid != 2'b00) begin
          grant_vec[gnt_sel] = 1'b1;
          gnt_d    = gnt_sel;
          ptr_d    = ~gnt_sel;
          opcode_d = op_arr[gnt_sel];
          a_d      = a_arr[gnt_sel];
          b_d      = b_arr[gnt_sel];
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        resp_data_d = alu_result;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        resp_vec[gnt_q] = 1'b1;
        if (resp_ready[gnt_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      opcode_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      opcode_q    <= opcode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      resp_data_q <= resp_data_d;
    end
  end

  flag_reg #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_flag_reg (
    .clk      (clk),
    .rst      (rst),
    .update_i (state_q == ST_EXEC),
    .opcode_i (opcode_q),
    .result_i (alu_result),
    .ovfl_i   (alu_ovfl),
    .flags_o  (flags)
  );

  // Reset also masks the combinational grant so no handshake leaks out.
  assign req_ready  = rst ? 2'b00 : grant_vec;
  assign resp_valid = resp_vec;
  assign resp_data  = resp_data_q;
  assign alu_opcode = opcode_q;
  assign alu_op1    = a_q;
  assign alu_op2    = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic against a behavioural arbiter/flag model and a behavioural ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_op1;
  logic [15:0] alu_op2;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [15:0] resp_data;
  logic [2:0]  flags;

  int n_checks = 0;
  int n_pass   = 0;
  int ptr_m;
  logic [2:0] flags_m;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(16), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_ovfl(alu_ovfl),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .flags(flags)
  );

  function automatic logic [16:0] alu_calc(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        ov;
    ov = 1'b0;
    case (op)
      4'b0000: begin r = a + b; ov = (a[15] == b[15]) && (r[15] != a[15]); end
      4'b0001: begin r = a - b; ov = (a[15] != b[15]) && (r[15] != a[15]); end
      4'b0010: r = a ^ b;
      4'b0011: r = a & b;
      4'b0100: r = a << b[3:0];
      4'b0101: r = 16'($signed(a) >>> b[3:0]);
      4'b0110: r = (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]}));
      4'b0111: r = a | b;
      4'b1010: r = {a[15:8], b[7:0]};
      default: r = ~a;
    endcase
    return {ov, r};
  endfunction

  always_comb {alu_ovfl, alu_result} = alu_calc(alu_opcode, alu_op1, alu_op2);

  function automatic logic [2:0] next_flags(input logic [2:0] f, input logic [3:0] op, input logic [16:0] res);
    logic [2:0] nf;
    nf = f;
    if (op == 4'b0000 || op == 4'b0001) nf = {res[16], res[15], res[15:0] == 16'h0000};
    else if (op == 4'b0010 || op == 4'b0100 || op == 4'b0101 || op == 4'b0110) nf[0] = (res[15:0] == 16'h0000);
    return nf;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    req_opcode = '0; req_a = '0; req_b = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    ptr_m = 0; flags_m = 3'b000;
  endtask

  // Drives one request and its response handshake; returns observations only.
  task automatic do_txn(input logic [1:0] v,
                        input logic [3:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                        input logic [3:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                        input int hold,
                        output logic [1:0] gnt, output int lat, output logic [1:0] rv,
                        output logic [15:0] data, output logic [2:0] flg,
                        output bit stable, output bit to);
    int k;
    to = 0; stable = 1; lat = 0; gnt = 2'b00; rv = 2'b00; data = '0; flg = '0;
    req_valid = v; req_opcode = {op1, op0}; req_a = {a1, a0}; req_b = {b1, b0};
    resp_ready = 2'b00;
    #1; k = 0;
    while (req_ready == 2'b00 && k < 20) begin @(negedge clk); #1; k++; end
    if (req_ready == 2'b00) begin to = 1; req_valid = 2'b00; return; end
    gnt = req_ready;
    @(posedge clk); #1;
    req_valid = v & ~gnt;
    while (resp_valid == 2'b00 && lat < 10) begin @(negedge clk); #1; lat++; end
    if (resp_valid == 2'b00) begin to = 1; return; end
    rv = resp_valid; data = resp_data; flg = flags;
    for (int h = 0; h < hold; h++) begin
      req_valid = 2'b11; resp_ready = ~gnt;
      #1;
      if (req_ready != 2'b00 || resp_valid != rv || resp_data != data) stable = 0;
      @(negedge clk); #1;
      if (req_ready != 2'b00 || resp_valid != rv || resp_data != data) stable = 0;
    end
    req_valid = v & ~gnt; resp_ready = gnt;
    @(negedge clk);
    resp_ready = 2'b00; req_valid = 2'b00;
    $display("txn v=%b gnt=%b lat=%0d data=%h flags=%b", v, gnt, lat, data, flg);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; resp_ready = 2'b11;
    req_opcode = 8'h21; req_a = 32'h1234_5678; req_b = 32'h9abc_def0;
    @(negedge clk); #1;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got=%b exp=00", req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 2'b00) $display("FAIL reset_resp_valid got=%b exp=00", resp_valid); else n_pass++;
    n_checks++; if (flags !== 3'b000) $display("FAIL reset_flags got=%b exp=000", flags); else n_pass++;
    n_checks++; if (resp_data !== 16'h0000) $display("FAIL reset_resp_data got=%h exp=0000", resp_data); else n_pass++;
    n_checks++; if ({alu_opcode, alu_op1, alu_op2} !== 36'h0) $display("FAIL reset_alu_regs got=%h/%h/%h exp=0", alu_opcode, alu_op1, alu_op2); else n_pass++;
    do_reset();
  endtask

  task automatic test_add_ovfl();
    logic [1:0] g, rv; int lat; logic [15:0] d; logic [2:0] f; bit st, to;
    do_txn(2'b01, 4'b0000, 16'h7FFF, 16'h0001, 4'b0000, 16'h0, 16'h0, 0, g, lat, rv, d, f, st, to);
    n_checks++; if (to) $display("FAIL add_timeout got=timeout exp=response"); else n_pass++;
    n_checks++; if (g !== 2'b01) $display("FAIL add_req_ready got=%b exp=01", g); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL add_latency got=%0d exp=2", lat); else n_pass++;
    n_checks++; if (rv !== 2'b01) $display("FAIL add_resp_valid got=%b exp=01", rv); else n_pass++;
    n_checks++; if (d !== 16'h8000) $display("FAIL add_resp_data got=%h exp=8000", d); else n_pass++;
    n_checks++; if (f !== 3'b110) $display("FAIL add_flags got=%b exp=110", f); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] g, rv; int lat; logic [15:0] d; logic [2:0] f; bit st, to;
    do_reset();
    do_txn(2'b11, 4'b0001, 16'd5, 16'd5, 4'b0010, 16'h00F0, 16'h000F, 0, g, lat, rv, d, f, st, to);
    n_checks++; if (to || g !== 2'b01) $display("FAIL rr_first_grant got=%b exp=01", g); else n_pass++;
    n_checks++; if (f !== 3'b001) $display("FAIL rr_sub_flags got=%b exp=001", f); else n_pass++;
    do_txn(2'b11, 4'b0001, 16'd5, 16'd5, 4'b0010, 16'h00F0, 16'h000F, 0, g, lat, rv, d, f, st, to);
    n_checks++; if (to || g !== 2'b10) $display("FAIL rr_second_grant got=%b exp=10", g); else n_pass++;
    n_checks++; if (rv !== 2'b10 || d !== 16'h00FF) $display("FAIL rr_xor_resp got=%b/%h exp=10/00ff", rv, d); else n_pass++;
    n_checks++; if (f !== 3'b000) $display("FAIL rr_xor_flags got=%b exp=000", f); else n_pass++;
    do_txn(2'b11, 4'b0011, 16'h0F0F, 16'h00FF, 4'b0011, 16'h0, 16'h0, 0, g, lat, rv, d, f, st, to);
    n_checks++; if (to || g !== 2'b01) $display("FAIL rr_third_grant got=%b exp=01", g); else n_pass++;
  endtask

  task automatic test_sll_zero();
    logic [1:0] g, rv; int lat; logic [15:0] d; logic [2:0] f; bit st, to;
    do_txn(2'b01, 4'b0000, 16'h7FFF, 16'h0001, 4'b0000, 16'h0, 16'h0, 0, g, lat, rv, d, f, st, to);
    n_checks++; if (to || f !== 3'b110) $display("FAIL sll_pre_flags got=%b exp=110", f); else n_pass++;
    do_txn(2'b10, 4'b0000, 16'h0, 16'h0, 4'b0100, 16'h8000, 16'h0001, 0, g, lat, rv, d, f, st, to);
    n_checks++; if (to || g !== 2'b10 || d !== 16'h0000) $display("FAIL sll_resp got=%b/%h exp=10/0000", g, d); else n_pass++;
    n_checks++; if (f !== 3'b111) $display("FAIL sll_flags got=%b exp=111", f); else n_pass++;
  endtask

  task automatic test_llb();
    logic [1:0] g, rv; int lat; logic [15:0] d; logic [2:0] f; bit st, to;
    do_txn(2'b01, 4'b1010, 16'h1200, 16'h0034, 4'b0000, 16'h0, 16'h0, 0, g, lat, rv, d, f, st, to);
    n_checks++; if (to || d !== 16'h1234) $display("FAIL llb_resp_data got=%h exp=1234", d); else n_pass++;
    n_checks++; if (f !== 3'b111) $display("FAIL llb_flags got=%b exp=111", f); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [1:0] g, rv; int lat; logic [15:0] d; logic [2:0] f; bit st, to;
    do_txn(2'b01, 4'b0010, 16'hA5A5, 16'h0F0F, 4'b0000, 16'h1, 16'h1, 5, g, lat, rv, d, f, st, to);
    n_checks++; if (to || d !== 16'hAAAA) $display("FAIL bp_resp_data got=%h exp=aaaa", d); else n_pass++;
    n_checks++; if (!st) $display("FAIL bp_stable got=unstable exp=stable"); else n_pass++;
    n_checks++; if (f !== 3'b110) $display("FAIL bp_flags got=%b exp=110", f); else n_pass++;
  endtask

  task automatic test_reset_exec();
    logic [1:0] g, rv; int lat; logic [15:0] d; logic [2:0] f; bit st, to;
    int bad;
    do_reset();
    req_valid = 2'b01; req_opcode = 8'h00; req_a = {16'h0, 16'h7FFF}; req_b = {16'h0, 16'h0001};
    #1;
    n_checks++; if (req_ready !== 2'b01) $display("FAIL rexec_grant got=%b exp=01", req_ready); else n_pass++;
    @(posedge clk); #1;
    req_valid = 2'b11; rst = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL rexec_req_ready got=%b exp=00", req_ready); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (flags !== 3'b000 || resp_valid !== 2'b00) $display("FAIL rexec_state got=%b/%b exp=000/00", flags, resp_valid); else n_pass++;
    rst = 1'b0; req_valid = 2'b00; ptr_m = 0; flags_m = 3'b000;
    bad = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); #1; if (resp_valid != 2'b00) bad++; end
    n_checks++; if (bad != 0) $display("FAIL rexec_no_resp got=%0d exp=0", bad); else n_pass++;
    @(negedge clk);
    do_txn(2'b10, 4'b0000, 16'h0, 16'h0, 4'b0000, 16'd1, 16'd1, 0, g, lat, rv, d, f, st, to);
    n_checks++; if (to || g !== 2'b10 || lat !== 2 || d !== 16'd2 || f !== 3'b000) $display("FAIL rexec_after got=%b/%0d/%h/%b exp=10/2/0002/000", g, lat, d, f); else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] g, rv, v, eg; int lat; logic [15:0] d; logic [2:0] f; bit st, to;
    logic [3:0] ops [10];
    logic [3:0] o0, o1, eo; logic [15:0] x0, y0, x1, y1, ea, eb;
    logic [16:0] res;
    int hold, ei;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1010, 4'b1111};
    do_reset();
    for (int t = 0; t < 40; t++) begin
      v = 2'($urandom_range(1, 3));
      o0 = ops[$urandom_range(0, 9)]; o1 = ops[$urandom_range(0, 9)];
      x0 = 16'($urandom); y0 = 16'($urandom); x1 = 16'($urandom); y1 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) y0 = x0;
      hold = $urandom_range(0, 3);
      ei = (v == 2'b11) ? ptr_m : ((v == 2'b10) ? 1 : 0);
      ptr_m = 1 - ei;
      eg = (ei == 1) ? 2'b10 : 2'b01;
      eo = (ei == 1) ? o1 : o0; ea = (ei == 1) ? x1 : x0; eb = (ei == 1) ? y1 : y0;
      res = alu_calc(eo, ea, eb);
      flags_m = next_flags(flags_m, eo, res);
      do_txn(v, o0, x0, y0, o1, x1, y1, hold, g, lat, rv, d, f, st, to);
      n_checks++; if (to) $display("FAIL rnd%0d_timeout got=timeout exp=response", t); else n_pass++;
      n_checks++; if (g !== eg || rv !== eg) $display("FAIL rnd%0d_grant got=%b/%b exp=%b", t, g, rv, eg); else n_pass++;
      n_checks++; if (lat !== 2) $display("FAIL rnd%0d_latency got=%0d exp=2", t, lat); else n_pass++;
      n_checks++; if (d !== res[15:0]) $display("FAIL rnd%0d_data got=%h exp=%h", t, d, res[15:0]); else n_pass++;
      n_checks++; if (f !== flags_m) $display("FAIL rnd%0d_flags got=%b exp=%b", t, f, flags_m); else n_pass++;
      n_checks++; if (!st) $display("FAIL rnd%0d_hold got=unstable exp=stable", t); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add_ovfl();
    test_round_robin();
    test_sll_zero();
    test_llb();
    test_backpressure();
    test_reset_exec();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
